// File: rtl/axil_mem_master_if.sv
// AXI4-lite bus bundle between axil_mem_master and its slave.
// The master drives address/data/valid and the response readies; the slave drives the rest.
interface axil_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_mem_master.sv
// Single-outstanding AXI4-lite master for core loads/stores: byte-lane steering,
// load extension, misalignment trap and a bus timeout.
module axil_mem_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_instr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_code,
  axil_mem_master_if.master axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_ALIGN = 2'b01;
  localparam logic [1:0] CODE_BUS   = 2'b10;
  localparam logic [1:0] CODE_TMO   = 2'b11;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [LANE_W-1:0] lane_q;
  logic [1:0]        size_q;
  logic              unsigned_q;

  logic [LANE_W-1:0] req_lane;
  logic [ADDR_W-1:0] aligned_addr;
  logic [2:0]        req_prot;
  logic              misaligned;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] keep_mask;
  logic              fill;
  logic [DATA_W-1:0] load_ext;
  logic              busy;
  logic              timeout_hit;
  logic              aw_left;
  logic              w_left;

  assign req_ready    = (state == S_IDLE);
  assign rsp_valid    = (state == S_RESP);
  assign req_lane     = req_addr[LANE_W-1:0];
  assign aligned_addr = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign req_prot     = req_instr ? 3'b101 : 3'b000;
  assign busy         = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                        (state == S_WR_REQ)  || (state == S_WR_RESP);
  assign timeout_hit  = (TIMEOUT != 0) && busy && (cnt == CNT_LAST);
  assign aw_left      = axi.awvalid && !axi.awready;
  assign w_left       = axi.wvalid && !axi.wready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'hFF;
    case (req_size)
      2'd0: strb_base = 8'h01;
      2'd1: begin misaligned = req_addr[0];    strb_base = 8'h03; end
      2'd2: begin misaligned = |req_addr[1:0]; strb_base = 8'h0F; end
      default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  // Load data: move the addressed lane to bit 0, keep the access width, extend.
  assign rshift = axi.rdata >> {lane_q, 3'b000};
  always_comb begin
    keep_mask = '1;
    fill      = 1'b0;
    case (size_q)
      2'd0: begin keep_mask = DATA_W'(8'hFF);         fill = rshift[7];  end
      2'd1: begin keep_mask = DATA_W'(16'hFFFF);      fill = rshift[15]; end
      2'd2: begin keep_mask = DATA_W'(32'hFFFF_FFFF); fill = rshift[31]; end
      default: fill = 1'b0;
    endcase
    fill     = fill & ~unsigned_q;
    load_ext = (rshift & keep_mask) | (~keep_mask & {DATA_W{fill}});
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      rsp_rdata   <= '0;
      rsp_code    <= CODE_OK;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awprot  <= 3'b000;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arprot  <= 3'b000;
      axi.rready  <= 1'b0;
    end else if (timeout_hit) begin
      // A hung slave wins over any handshake completing on the same edge.
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      rsp_rdata   <= '0;
      rsp_code    <= CODE_TMO;
      state       <= S_RESP;
    end else begin
      if (busy) cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt        <= '0;
            lane_q     <= req_lane;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (misaligned) begin
              rsp_rdata <= '0;
              rsp_code  <= CODE_ALIGN;
              state     <= S_RESP;
            end else if (req_write) begin
              axi.awvalid <= 1'b1;
              axi.awaddr  <= aligned_addr;
              axi.awprot  <= req_prot;
              axi.wvalid  <= 1'b1;
              axi.wdata   <= req_wdata << {req_lane, 3'b000};
              axi.wstrb   <= STRB_W'(strb_base) << req_lane;
              state       <= S_WR_REQ;
            end else begin
              axi.arvalid <= 1'b1;
              axi.araddr  <= aligned_addr;
              axi.arprot  <= req_prot;
              state       <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            if (axi.rresp inside {2'b10, 2'b11}) begin
              rsp_rdata <= '0;
              rsp_code  <= CODE_BUS;
            end else begin
              rsp_rdata <= load_ext;
              rsp_code  <= CODE_OK;
            end
            state <= S_RESP;
          end
        end
        S_WR_REQ: begin
          axi.awvalid <= aw_left;
          axi.wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            axi.bready <= 1'b1;
            state      <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rsp_rdata  <= '0;
            rsp_code   <= (axi.bresp inside {2'b10, 2'b11}) ? CODE_BUS : CODE_OK;
            state      <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
